// File: rtl/irrigacao_pkg.sv
// irrigacao_pkg: state/grant encodings and default timing parameters for the irrigation sequencer
package irrigacao_pkg;
  typedef enum logic [2:0] {IDLE = 3'd0, PRIME = 3'd1, RUN = 3'd2, COOL = 3'd3, FAULT = 3'd4} state_t;
  typedef enum logic {ASP = 1'b0, GOT = 1'b1} grant_t;
  localparam int PRIME_CYC_DEF = 2;
  localparam int MIN_ON_DEF = 8;
  localparam int MAX_ON_DEF = 1000;
  localparam int COOLDOWN_DEF = 4;
  localparam int CNT_W_DEF = 16;
endpackage

// File: rtl/controle_irrigacao_if.sv
// controle_irrigacao_if: request/sensor inputs and valve/pump/status outputs; master drives requests, slave is the sequencer
interface controle_irrigacao_if;
  logic reqAspersao;
  logic reqGotejamento;
  logic alarme;
  logic nivelBaixo;
  logic valvulaAspersao;
  logic valvulaGotejamento;
  logic bomba;
  logic falha;
  logic timeoutPulse;
  logic [2:0] estado;
  modport master(
    output reqAspersao, reqGotejamento, alarme, nivelBaixo,
    input valvulaAspersao, valvulaGotejamento, bomba, falha, timeoutPulse, estado
  );
  modport slave(
    input reqAspersao, reqGotejamento, alarme, nivelBaixo,
    output valvulaAspersao, valvulaGotejamento, bomba, falha, timeoutPulse, estado
  );
endinterface

// File: rtl/arbitro_irrigacao.sv
// arbitro_irrigacao: combinational 2-way round-robin (req_asp, req_got, last_grant -> grant, valid)
module arbitro_irrigacao
  import irrigacao_pkg::*;
(
  input  logic   req_asp,
  input  logic   req_got,
  input  grant_t last_grant,
  output grant_t grant,
  output logic   valid
);
  assign valid = req_asp | req_got;
  assign grant = (req_asp & req_got) ? grant_t'(~last_grant) : (req_asp ? ASP : GOT);
endmodule

// File: rtl/controle_irrigacao.sv
// controle_irrigacao: pump/valve sequencer (clock, reset_n, bus slave: requests/alarm/level in, valves/pump/falha/timeoutPulse/estado out)
module controle_irrigacao
  import irrigacao_pkg::*;
#(
  parameter int PRIME_CYC = PRIME_CYC_DEF,
  parameter int MIN_ON    = MIN_ON_DEF,
  parameter int MAX_ON    = MAX_ON_DEF,
  parameter int COOLDOWN  = COOLDOWN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input logic clock,
  input logic reset_n,
  controle_irrigacao_if.slave bus
);
  state_t state_q, state_d;
  grant_t grant_q, grant_d, last_q, last_d, arb_grant;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic to_q, to_d, arb_valid, req_cur;
  arbitro_irrigacao u_arb (
    .req_asp   (bus.reqAspersao),
    .req_got   (bus.reqGotejamento),
    .last_grant(last_q),
    .grant     (arb_grant),
    .valid     (arb_valid)
  );
  assign req_cur = (grant_q == ASP) ? bus.reqAspersao : bus.reqGotejamento;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      grant_q <= ASP;
      last_q  <= GOT;
      cnt_q   <= '0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      to_q    <= to_d;
    end
  end
  // Every entry into COOL from a grant records it for round-robin; entry from FAULT does not.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    cnt_d   = cnt_q + CNT_W'(1);
    to_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (bus.alarme) state_d = FAULT;
        else if (!bus.nivelBaixo && arb_valid) begin
          state_d = PRIME;
          grant_d = arb_grant;
        end
      end
      PRIME: begin
        if (bus.alarme) state_d = FAULT;
        else if (bus.nivelBaixo) begin
          state_d = COOL;
          last_d  = grant_q;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(PRIME_CYC - 1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end
      end
      RUN: begin
        if (bus.alarme) state_d = FAULT;
        else if (bus.nivelBaixo || cnt_q == CNT_W'(MAX_ON - 1) || (!req_cur && cnt_q >= CNT_W'(MIN_ON - 1))) begin
          state_d = COOL;
          last_d  = grant_q;
          cnt_d   = '0;
          to_d    = !bus.nivelBaixo && cnt_q == CNT_W'(MAX_ON - 1);
        end
      end
      COOL: begin
        if (bus.alarme) state_d = FAULT;
        else if (cnt_q == CNT_W'(COOLDOWN - 1)) state_d = IDLE;
      end
      FAULT: begin
        cnt_d = '0;
        if (!bus.alarme) state_d = COOL;
      end
      default: state_d = IDLE;
    endcase
  end
  assign bus.valvulaAspersao    = (state_q == PRIME || state_q == RUN) && grant_q == ASP;
  assign bus.valvulaGotejamento = (state_q == PRIME || state_q == RUN) && grant_q == GOT;
  assign bus.bomba              = state_q == RUN;
  assign bus.falha              = state_q == FAULT;
  assign bus.timeoutPulse       = to_q;
  assign bus.estado             = state_q;
endmodule

// File: tb/tb_controle_irrigacao.sv
// tb_controle_irrigacao: directed scenarios with a phase/countdown reference model checked every cycle
module tb_controle_irrigacao;
  localparam int PRIME_CYC = 2, MIN_ON = 8, MAX_ON = 20, COOLDOWN = 4;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int checks = 0;
  int failures = 0;
  bit checking = 1'b0;
  controle_irrigacao_if bus();
  controle_irrigacao #(.PRIME_CYC(PRIME_CYC), .MIN_ON(MIN_ON), .MAX_ON(MAX_ON), .COOLDOWN(COOLDOWN), .CNT_W(16)) dut (
    .clock  (clock),
    .reset_n(reset_n),
    .bus    (bus)
  );
  always #5 clock = ~clock;
  int m_phase = 0, m_left = 0, m_run = 0, m_grant = 0, m_last = 1;
  bit m_to = 1'b0;
  function automatic bit m_req(int g);
    return g == 0 ? bus.reqAspersao : bus.reqGotejamento;
  endfunction
  task automatic m_cool();
    m_phase = 3;
    m_left  = COOLDOWN;
    m_last  = m_grant;
  endtask
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_phase = 0; m_left = 0; m_run = 0; m_grant = 0; m_last = 1; m_to = 1'b0;
    end else begin
      m_to = 1'b0;
      if (bus.alarme) m_phase = 4;
      else case (m_phase)
        0: if (!bus.nivelBaixo && (bus.reqAspersao || bus.reqGotejamento)) begin
          m_grant = (bus.reqAspersao && bus.reqGotejamento) ? 1 - m_last : (bus.reqAspersao ? 0 : 1);
          m_phase = 1;
          m_left  = PRIME_CYC;
        end
        1: if (bus.nivelBaixo) m_cool();
        else begin
          m_left--;
          if (m_left == 0) begin m_phase = 2; m_run = 0; end
        end
        2: if (bus.nivelBaixo) m_cool();
        else begin
          m_run++;
          if (m_run == MAX_ON) begin m_cool(); m_to = 1'b1; end
          else if (m_run >= MIN_ON && !m_req(m_grant)) m_cool();
        end
        3: begin
          m_left--;
          if (m_left == 0) m_phase = 0;
        end
        default: begin m_phase = 3; m_left = COOLDOWN; end
      endcase
    end
  end
  task automatic chk(string n, int got, int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", n, got, exp, $time);
    end
  endtask
  always @(negedge clock) if (checking) begin
    chk("m_estado", int'(bus.estado), m_phase);
    chk("m_valv_asp", int'(bus.valvulaAspersao), int'((m_phase == 1 || m_phase == 2) && m_grant == 0));
    chk("m_valv_got", int'(bus.valvulaGotejamento), int'((m_phase == 1 || m_phase == 2) && m_grant == 1));
    chk("m_bomba", int'(bus.bomba), int'(m_phase == 2));
    chk("m_falha", int'(bus.falha), int'(m_phase == 4));
    chk("m_timeout", int'(bus.timeoutPulse), int'(m_to));
  end
  task automatic tick(int n);
    repeat (n) @(posedge clock);
    #1;
  endtask
  initial begin
    bus.reqAspersao = 0; bus.reqGotejamento = 0; bus.alarme = 0; bus.nivelBaixo = 0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    checking = 1'b1;
    chk("rst_estado", int'(bus.estado), 0);
    chk("rst_bomba", int'(bus.bomba), 0);
    chk("rst_valv", int'(bus.valvulaAspersao | bus.valvulaGotejamento), 0);
    chk("rst_falha", int'(bus.falha | bus.timeoutPulse), 0);
    bus.reqAspersao = 1; tick(1);
    chk("s1_valve", int'(bus.valvulaAspersao), 1);
    chk("s1_prime_pump0", int'(bus.bomba), 0);
    tick(1); chk("s1_prime2_pump0", int'(bus.bomba), 0);
    tick(1); chk("s1_pump_on", int'(bus.bomba), 1);
    tick(19); chk("s1_run20", int'(bus.estado), 2);
    tick(1); chk("s1_cool", int'(bus.estado), 3);
    chk("s1_timeout", int'(bus.timeoutPulse), 1);
    bus.reqAspersao = 0; tick(1);
    chk("s1_timeout_1cyc", int'(bus.timeoutPulse), 0);
    tick(2); chk("s1_cool_last", int'(bus.estado), 3);
    tick(1); chk("s1_idle", int'(bus.estado), 0);
    bus.reqGotejamento = 1; tick(1); bus.reqGotejamento = 0;
    chk("s2_valve", int'(bus.valvulaGotejamento), 1);
    chk("s2_prime", int'(bus.estado), 1);
    tick(2); chk("s2_pump_on", int'(bus.bomba), 1);
    tick(7); chk("s2_pump_8th", int'(bus.bomba), 1);
    tick(1); chk("s2_pump_off", int'(bus.bomba), 0);
    chk("s2_cool", int'(bus.estado), 3);
    tick(4); chk("s2_idle", int'(bus.estado), 0);
    bus.reqAspersao = 1; bus.reqGotejamento = 1; tick(1);
    chk("s3_first_asp", int'(bus.valvulaAspersao), 1);
    tick(22); chk("s3_timeout1", int'(bus.timeoutPulse), 1);
    tick(4); chk("s3_idle", int'(bus.estado), 0);
    tick(1); chk("s3_then_got", int'(bus.valvulaGotejamento), 1);
    tick(22); chk("s3_timeout2", int'(bus.timeoutPulse), 1);
    tick(5); chk("s3_back_asp", int'(bus.valvulaAspersao), 1);
    bus.reqAspersao = 0; bus.reqGotejamento = 0;
    tick(14); chk("s3_idle_end", int'(bus.estado), 0);
    bus.reqAspersao = 1; tick(3); tick(4);
    chk("s4_run5", int'(bus.estado), 2);
    bus.alarme = 1; tick(1);
    chk("s4_falha", int'(bus.falha), 1);
    chk("s4_water_off", int'(bus.bomba | bus.valvulaAspersao), 0);
    chk("s4_fault", int'(bus.estado), 4);
    bus.reqAspersao = 0; tick(2);
    chk("s4_fault_hold", int'(bus.falha), 1);
    bus.alarme = 0; tick(1);
    chk("s4_cool", int'(bus.estado), 3);
    tick(3); chk("s4_cool4", int'(bus.estado), 3);
    tick(1); chk("s4_idle", int'(bus.estado), 0);
    bus.nivelBaixo = 1; bus.reqAspersao = 1; tick(3);
    chk("s5_no_grant", int'(bus.estado), 0);
    chk("s5_valve0", int'(bus.valvulaAspersao), 0);
    bus.nivelBaixo = 0; tick(1);
    chk("s5_prime", int'(bus.estado), 1);
    bus.nivelBaixo = 1; tick(1);
    chk("s5_cool", int'(bus.estado), 3);
    chk("s5_pump0", int'(bus.bomba), 0);
    bus.reqAspersao = 0; bus.nivelBaixo = 0; tick(4);
    chk("s5_idle", int'(bus.estado), 0);
    bus.reqGotejamento = 1; tick(6);
    chk("s6_run", int'(bus.bomba & bus.valvulaGotejamento), 1);
    #2 reset_n = 1'b0;
    #1;
    chk("s6_async_estado", int'(bus.estado), 0);
    chk("s6_async_bomba", int'(bus.bomba), 0);
    chk("s6_async_valve", int'(bus.valvulaGotejamento), 0);
    bus.reqAspersao = 1; tick(2);
    reset_n = 1'b1; tick(1);
    chk("s6_asp_first", int'(bus.valvulaAspersao), 1);
    chk("s6_got_wait", int'(bus.valvulaGotejamento), 0);
    bus.reqAspersao = 0; bus.reqGotejamento = 0;
    tick(14); chk("s6_idle", int'(bus.estado), 0);
    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
